// File: rtl/sc_mm_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sc_mm_sequencer_if : memory ports and wrapper handshake of the MM sequencer
// Revision 1.0
// ---------------------------------------------------------------------------
interface sc_mm_sequencer_if #(
  parameter int BATCH_SIZE       = 4,
  parameter int INPUT_FEATURES   = 4,
  parameter int OUTPUT_FEATURES  = 4,
  parameter int BINARY_PRECISION = 32,
  parameter int ADDR_WIDTH       = 8
);
  localparam int P = BINARY_PRECISION;

  logic                                         start;
  logic                                         busy;
  logic                                         done;
  logic                                         in_rd_en;
  logic [ADDR_WIDTH-1:0]                        in_rd_addr;
  logic [P-1:0]                                 in_rd_data;
  logic                                         w_rd_en;
  logic [ADDR_WIDTH-1:0]                        w_rd_addr;
  logic [P-1:0]                                 w_rd_data;
  logic [P*BATCH_SIZE*INPUT_FEATURES-1:0]       input_matrix;
  logic [P*OUTPUT_FEATURES*INPUT_FEATURES-1:0]  weight_matrix;
  logic                                         enable;
  logic [P*BATCH_SIZE*OUTPUT_FEATURES-1:0]      output_matrix;
  logic                                         outputWrEn;
  logic                                         out_wr_en;
  logic [ADDR_WIDTH-1:0]                        out_wr_addr;
  logic [P-1:0]                                 out_wr_data;

  modport master (
    input  start, in_rd_data, w_rd_data, output_matrix, outputWrEn,
    output busy, done, in_rd_en, in_rd_addr, w_rd_en, w_rd_addr,
           input_matrix, weight_matrix, enable, out_wr_en, out_wr_addr, out_wr_data
  );

  modport slave (
    output start, in_rd_data, w_rd_data, output_matrix, outputWrEn,
    input  busy, done, in_rd_en, in_rd_addr, w_rd_en, w_rd_addr,
           input_matrix, weight_matrix, enable, out_wr_en, out_wr_addr, out_wr_data
  );
endinterface
`default_nettype wire

// File: rtl/sc_mm_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sc_mm_sequencer : fetches input/weight matrices, runs the wrapper, stores result
// Revision 1.0
// ---------------------------------------------------------------------------
module sc_mm_sequencer #(
  parameter int BATCH_SIZE       = 4,
  parameter int INPUT_FEATURES   = 4,
  parameter int OUTPUT_FEATURES  = 4,
  parameter int BINARY_PRECISION = 32,
  parameter int ADDR_WIDTH       = 8
) (
  input  logic              clk,
  input  logic              rst,
  sc_mm_sequencer_if.master bus
);
  localparam int P    = BINARY_PRECISION;
  localparam int MN   = BATCH_SIZE * INPUT_FEATURES;
  localparam int ON   = OUTPUT_FEATURES * INPUT_FEATURES;
  localparam int MO   = BATCH_SIZE * OUTPUT_FEATURES;
  localparam int MAXC = (MN > ON) ? ((MN > MO) ? MN : MO) : ((ON > MO) ? ON : MO);
  localparam int CW   = $clog2(MAXC) + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_IN = 3'd1,
    S_LOAD_W  = 3'd2,
    S_COMPUTE = 3'd3,
    S_STORE   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_cnt, w_cnt_nxt;
  logic [P*MN-1:0]     r_in_mat;
  logic [P*ON-1:0]     r_w_mat;
  logic [P*MO-1:0]     r_result, w_result_nxt;
  logic                r_busy, r_done, r_enable, r_in_rd_en, r_w_rd_en, r_out_wr_en;
  logic [ADDR_WIDTH-1:0] r_in_rd_addr, r_w_rd_addr, r_out_wr_addr;
  logic [P-1:0]        r_out_wr_data;
  logic                w_in_rd_en_nxt, w_w_rd_en_nxt, w_out_wr_en_nxt;
  logic [P-1:0]        w_out_wr_data_nxt;

  // Outputs are registered copies of what the next state/count will require.
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_result_nxt      = r_result;
    w_out_wr_data_nxt = '0;
    unique case (r_state)
      S_IDLE: if (bus.start) begin
        w_state_nxt = S_LOAD_IN;
        w_cnt_nxt   = '0;
      end
      S_LOAD_IN: if (r_cnt == CW'(MN)) begin
        w_state_nxt = S_LOAD_W;
        w_cnt_nxt   = '0;
      end else w_cnt_nxt = r_cnt + CW'(1);
      S_LOAD_W: if (r_cnt == CW'(ON)) begin
        w_state_nxt = S_COMPUTE;
        w_cnt_nxt   = '0;
      end else w_cnt_nxt = r_cnt + CW'(1);
      S_COMPUTE: if (bus.outputWrEn) begin
        w_state_nxt  = S_STORE;
        w_cnt_nxt    = '0;
        w_result_nxt = bus.output_matrix;
      end
      S_STORE: if (r_cnt == CW'(MO - 1)) begin
        w_state_nxt = S_DONE;
        w_cnt_nxt   = '0;
      end else w_cnt_nxt = r_cnt + CW'(1);
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    w_in_rd_en_nxt  = (w_state_nxt == S_LOAD_IN) && (w_cnt_nxt < CW'(MN));
    w_w_rd_en_nxt   = (w_state_nxt == S_LOAD_W) && (w_cnt_nxt < CW'(ON));
    w_out_wr_en_nxt = (w_state_nxt == S_STORE);
    if (w_out_wr_en_nxt)
      for (int j = 0; j < MO; j++)
        if (w_cnt_nxt == CW'(j)) w_out_wr_data_nxt = w_result_nxt[j*P +: P];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_in_mat      <= '0;
      r_w_mat       <= '0;
      r_result      <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_enable      <= 1'b0;
      r_in_rd_en    <= 1'b0;
      r_w_rd_en     <= 1'b0;
      r_out_wr_en   <= 1'b0;
      r_in_rd_addr  <= '0;
      r_w_rd_addr   <= '0;
      r_out_wr_addr <= '0;
      r_out_wr_data <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_result      <= w_result_nxt;
      r_busy        <= (w_state_nxt != S_IDLE);
      r_done        <= (w_state_nxt == S_DONE);
      r_enable      <= (w_state_nxt == S_COMPUTE);
      r_in_rd_en    <= w_in_rd_en_nxt;
      r_w_rd_en     <= w_w_rd_en_nxt;
      r_out_wr_en   <= w_out_wr_en_nxt;
      r_in_rd_addr  <= w_in_rd_en_nxt  ? ADDR_WIDTH'(w_cnt_nxt) : '0;
      r_w_rd_addr   <= w_w_rd_en_nxt   ? ADDR_WIDTH'(w_cnt_nxt) : '0;
      r_out_wr_addr <= w_out_wr_en_nxt ? ADDR_WIDTH'(w_cnt_nxt) : '0;
      r_out_wr_data <= w_out_wr_data_nxt;
      // Read data lags the strobe by one cycle, so count c lands in slot c-1.
      for (int k = 0; k < MN; k++)
        if (r_state == S_LOAD_IN && r_cnt == CW'(k + 1)) r_in_mat[k*P +: P] <= bus.in_rd_data;
      for (int k = 0; k < ON; k++)
        if (r_state == S_LOAD_W && r_cnt == CW'(k + 1)) r_w_mat[k*P +: P] <= bus.w_rd_data;
    end
  end

  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.enable        = r_enable;
  assign bus.in_rd_en      = r_in_rd_en;
  assign bus.in_rd_addr    = r_in_rd_addr;
  assign bus.w_rd_en       = r_w_rd_en;
  assign bus.w_rd_addr     = r_w_rd_addr;
  assign bus.out_wr_en     = r_out_wr_en;
  assign bus.out_wr_addr   = r_out_wr_addr;
  assign bus.out_wr_data   = r_out_wr_data;
  assign bus.input_matrix  = r_in_mat;
  assign bus.weight_matrix = r_w_mat;
endmodule
`default_nettype wire

// File: tb/tb_sc_mm_sequencer.sv
`default_nettype none
// Testbench for sc_mm_sequencer: default 4x4x4 instance plus a 2x3x5 instance.
module tb_sc_mm_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sc_mm_sequencer_if #(.BATCH_SIZE(4), .INPUT_FEATURES(4), .OUTPUT_FEATURES(4),
                       .BINARY_PRECISION(32), .ADDR_WIDTH(8)) ia ();
  sc_mm_sequencer_if #(.BATCH_SIZE(2), .INPUT_FEATURES(3), .OUTPUT_FEATURES(5),
                       .BINARY_PRECISION(32), .ADDR_WIDTH(8)) ib ();

  sc_mm_sequencer #(.BATCH_SIZE(4), .INPUT_FEATURES(4), .OUTPUT_FEATURES(4),
                    .BINARY_PRECISION(32), .ADDR_WIDTH(8)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  sc_mm_sequencer #(.BATCH_SIZE(2), .INPUT_FEATURES(3), .OUTPUT_FEATURES(5),
                    .BINARY_PRECISION(32), .ADDR_WIDTH(8)) dut_b (.clk(clk), .rst(rst), .bus(ib));

  logic [31:0]  in_mem [256];
  logic [31:0]  w_mem  [256];
  logic [511:0] pat_a, garb_a;
  logic [319:0] pat_b;
  int total = 0;
  int bad   = 0;

  // Memories answer one cycle after the strobe.
  always @(posedge clk) begin
    ia.in_rd_data <= ia.in_rd_en ? in_mem[ia.in_rd_addr] : 32'hDEAD_0001;
    ia.w_rd_data  <= ia.w_rd_en  ? w_mem[ia.w_rd_addr]   : 32'hDEAD_0002;
    ib.in_rd_data <= ib.in_rd_en ? in_mem[ib.in_rd_addr] : 32'hDEAD_0003;
    ib.w_rd_data  <= ib.w_rd_en  ? w_mem[ib.w_rd_addr]   : 32'hDEAD_0004;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int ob_first_in, ob_n_in, ob_in_err, ob_first_w, ob_n_w, ob_w_err;
  int ob_first_en, ob_n_en, ob_first_out, ob_n_out, ob_out_err;
  int ob_done, ob_done_cnt, ob_busy_err, ob_busy_after;

  // Drives one job on instance A and records what it observed, cycle 1 = E0+1.
  task automatic run_job_a(input int k_resp, input bit spur, input bit glitch);
    ob_first_in = -1; ob_n_in = 0; ob_in_err = 0; ob_first_w = -1; ob_n_w = 0; ob_w_err = 0;
    ob_first_en = -1; ob_n_en = 0; ob_first_out = -1; ob_n_out = 0; ob_out_err = 0;
    ob_done = -1; ob_done_cnt = 0; ob_busy_err = 0; ob_busy_after = -1;
    ia.start = 1'b1;
    tick();
    ia.start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (ia.in_rd_en) begin
        if (ob_n_in == 0) ob_first_in = c;
        if (ia.in_rd_addr != 8'(ob_n_in)) ob_in_err++;
        ob_n_in++;
      end
      if (ia.w_rd_en) begin
        if (ob_n_w == 0) ob_first_w = c;
        if (ia.w_rd_addr != 8'(ob_n_w)) ob_w_err++;
        ob_n_w++;
      end
      if (ia.enable) begin
        if (ob_n_en == 0) ob_first_en = c;
        ob_n_en++;
      end
      if (ia.out_wr_en) begin
        if (ob_n_out == 0) ob_first_out = c;
        if (ia.out_wr_addr != 8'(ob_n_out) || ia.out_wr_data != 32'hA000 + 32'(ob_n_out)) ob_out_err++;
        ob_n_out++;
      end
      if (ia.done) begin
        ob_done_cnt++;
        if (ob_done < 0) ob_done = c;
      end
      if (!ia.busy && ob_done < 0) ob_busy_err++;
      if (ob_done >= 0 && c == ob_done + 1) begin
        ob_busy_after = int'(ia.busy);
        break;
      end
      ia.outputWrEn    = ia.enable && (ob_n_en == k_resp);
      ia.output_matrix = pat_a;
      if (spur && (ia.w_rd_en || ia.out_wr_en)) begin
        ia.outputWrEn    = 1'b1;
        ia.output_matrix = garb_a;
      end
      ia.start = glitch && (c == 3 || (ia.enable && ob_n_en == 1));
      tick();
    end
    ia.outputWrEn = 1'b0;
    ia.start      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ia.start = 1'($urandom); ia.outputWrEn = 1'($urandom);
      ib.start = 1'($urandom); ib.outputWrEn = 1'($urandom);
      for (int j = 0; j < 16; j++) ia.output_matrix[j*32 +: 32] = $urandom;
      for (int j = 0; j < 10; j++) ib.output_matrix[j*32 +: 32] = $urandom;
      tick();
    end
    total++; if ({ia.busy, ia.done, ia.enable, ia.in_rd_en, ia.w_rd_en, ia.out_wr_en} !== 6'b0) begin bad++; $display("FAIL reset_a_flags: got %b want 000000", {ia.busy, ia.done, ia.enable, ia.in_rd_en, ia.w_rd_en, ia.out_wr_en}); end
    total++; if ({ia.in_rd_addr, ia.w_rd_addr, ia.out_wr_addr, ia.out_wr_data} !== 56'b0) begin bad++; $display("FAIL reset_a_addr_data: got %h want 0", {ia.in_rd_addr, ia.w_rd_addr, ia.out_wr_addr, ia.out_wr_data}); end
    total++; if (ia.input_matrix !== 512'b0 || ia.weight_matrix !== 512'b0) begin bad++; $display("FAIL reset_a_matrices: got nonzero want 0"); end
    total++; if ({ib.busy, ib.done, ib.enable, ib.in_rd_en, ib.w_rd_en, ib.out_wr_en} !== 6'b0 || ib.out_wr_data !== 32'b0 || ib.input_matrix !== 192'b0 || ib.weight_matrix !== 480'b0) begin bad++; $display("FAIL reset_b_outputs: got busy=%b data=%h want all 0", ib.busy, ib.out_wr_data); end
    ia.start = 1'b0; ia.outputWrEn = 1'b0; ib.start = 1'b0; ib.outputWrEn = 1'b0;
    rst = 1'b0;
    tick();
    total++; if (ia.busy !== 1'b0 || ia.in_rd_en !== 1'b0) begin bad++; $display("FAIL reset_idle_hold: got busy=%b rd=%b want 0 0", ia.busy, ia.in_rd_en); end
  endtask

  task automatic test_full_job();
    run_job_a(5, 1'b0, 1'b0);
    total++; if (ob_first_in !== 1 || ob_n_in !== 16 || ob_in_err !== 0) begin bad++; $display("FAIL full_in_reads: got first=%0d n=%0d err=%0d want 1 16 0", ob_first_in, ob_n_in, ob_in_err); end
    total++; if (ob_first_w !== 18 || ob_n_w !== 16 || ob_w_err !== 0) begin bad++; $display("FAIL full_w_reads: got first=%0d n=%0d err=%0d want 18 16 0", ob_first_w, ob_n_w, ob_w_err); end
    total++; if (ob_first_en !== 35 || ob_n_en !== 5) begin bad++; $display("FAIL full_enable: got first=%0d n=%0d want 35 5", ob_first_en, ob_n_en); end
    total++; if (ob_first_out !== 40 || ob_n_out !== 16 || ob_out_err !== 0) begin bad++; $display("FAIL full_store: got first=%0d n=%0d err=%0d want 40 16 0", ob_first_out, ob_n_out, ob_out_err); end
    total++; if (ob_done !== 56 || ob_done_cnt !== 1) begin bad++; $display("FAIL full_done: got cycle=%0d pulses=%0d want 56 1", ob_done, ob_done_cnt); end
    total++; if (ob_busy_err !== 0 || ob_busy_after !== 0) begin bad++; $display("FAIL full_busy: got gaps=%0d after=%0d want 0 0", ob_busy_err, ob_busy_after); end
    for (int k = 0; k < 16; k++) begin
      total++; if (ia.input_matrix[k*32 +: 32] !== 32'(k + 1)) begin bad++; $display("FAIL full_in_slot%0d: got %h want %h", k, ia.input_matrix[k*32 +: 32], 32'(k + 1)); end
      total++; if (ia.weight_matrix[k*32 +: 32] !== 32'h100 + 32'(k)) begin bad++; $display("FAIL full_w_slot%0d: got %h want %h", k, ia.weight_matrix[k*32 +: 32], 32'h100 + 32'(k)); end
    end
  endtask

  task automatic test_spurious_handshake();
    run_job_a(5, 1'b1, 1'b0);
    total++; if (ob_n_en !== 5 || ob_first_out !== 40) begin bad++; $display("FAIL spur_capture_point: got en=%0d store_at=%0d want 5 40", ob_n_en, ob_first_out); end
    total++; if (ob_out_err !== 0 || ob_n_out !== 16) begin bad++; $display("FAIL spur_store_data: got err=%0d n=%0d want 0 16", ob_out_err, ob_n_out); end
    total++; if (ob_done !== 56) begin bad++; $display("FAIL spur_done: got %0d want 56", ob_done); end
  endtask

  task automatic test_start_ignored();
    run_job_a(5, 1'b0, 1'b1);
    total++; if (ob_n_in !== 16 || ob_in_err !== 0 || ob_n_w !== 16 || ob_w_err !== 0) begin bad++; $display("FAIL glitch_addresses: got in=%0d/%0d w=%0d/%0d want 16/0 16/0", ob_n_in, ob_in_err, ob_n_w, ob_w_err); end
    total++; if (ob_done !== 56 || ob_done_cnt !== 1 || ob_out_err !== 0) begin bad++; $display("FAIL glitch_done: got cycle=%0d pulses=%0d err=%0d want 56 1 0", ob_done, ob_done_cnt, ob_out_err); end
  endtask

  task automatic test_reset_mid_job();
    int acc;
    bit found;
    found = 1'b0;
    ia.start = 1'b1;
    tick();
    ia.start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (ia.w_rd_en && ia.w_rd_addr == 8'd2) begin found = 1'b1; break; end
      tick();
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL midrst_reach_w2: got %b want 1", found); end
    rst = 1'b1;
    tick();
    total++; if ({ia.busy, ia.done, ia.enable, ia.in_rd_en, ia.w_rd_en, ia.out_wr_en} !== 6'b0 || ia.w_rd_addr !== 8'd0) begin bad++; $display("FAIL midrst_flags: got %b addr=%h want 000000 00", {ia.busy, ia.done, ia.enable, ia.in_rd_en, ia.w_rd_en, ia.out_wr_en}, ia.w_rd_addr); end
    total++; if (ia.input_matrix !== 512'b0 || ia.weight_matrix !== 512'b0) begin bad++; $display("FAIL midrst_matrices: got nonzero want 0"); end
    rst = 1'b0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      acc += int'(ia.in_rd_en) + int'(ia.w_rd_en) + int'(ia.out_wr_en) + int'(ia.busy);
    end
    total++; if (acc !== 0) begin bad++; $display("FAIL midrst_abandoned: got %0d accesses want 0", acc); end
    run_job_a(3, 1'b0, 1'b0);
    total++; if (ob_done !== 54 || ob_out_err !== 0 || ob_n_out !== 16 || ob_in_err !== 0) begin bad++; $display("FAIL midrst_rerun: got done=%0d err=%0d n=%0d want 54 0 16", ob_done, ob_out_err, ob_n_out); end
    total++; if (ia.weight_matrix[15*32 +: 32] !== 32'h10F) begin bad++; $display("FAIL midrst_rerun_w15: got %h want 0000010f", ia.weight_matrix[15*32 +: 32]); end
  endtask

  task automatic test_back_to_back();
    int dc;
    int n_en;
    dc = -1; n_en = 0;
    ia.output_matrix = pat_a;
    ia.start = 1'b1;
    tick();
    for (int c = 1; c <= 120; c++) begin
      if (ia.enable) n_en++;
      ia.outputWrEn = ia.enable && (n_en == 1);
      if (ia.done) begin dc = c; break; end
      tick();
    end
    ia.outputWrEn = 1'b0;
    total++; if (dc !== 52) begin bad++; $display("FAIL b2b_done: got %0d want 52", dc); end
    tick();
    total++; if (ia.busy !== 1'b0 || ia.in_rd_en !== 1'b0) begin bad++; $display("FAIL b2b_idle_gap: got busy=%b rd=%b want 0 0", ia.busy, ia.in_rd_en); end
    tick();
    total++; if (ia.busy !== 1'b1 || ia.in_rd_en !== 1'b1 || ia.in_rd_addr !== 8'd0) begin bad++; $display("FAIL b2b_relaunch: got busy=%b rd=%b addr=%h want 1 1 00", ia.busy, ia.in_rd_en, ia.in_rd_addr); end
    ia.start = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_nonsquare();
    int f_in, n_in, f_w, n_w, f_out, n_out, e, n_en, dc;
    f_in = -1; n_in = 0; f_w = -1; n_w = 0; f_out = -1; n_out = 0; e = 0; n_en = 0; dc = -1;
    ib.output_matrix = pat_b;
    ib.start = 1'b1;
    tick();
    ib.start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (ib.in_rd_en) begin if (n_in == 0) f_in = c; if (ib.in_rd_addr != 8'(n_in)) e++; n_in++; end
      if (ib.w_rd_en) begin if (n_w == 0) f_w = c; if (ib.w_rd_addr != 8'(n_w)) e++; n_w++; end
      if (ib.out_wr_en) begin
        if (n_out == 0) f_out = c;
        if (ib.out_wr_addr != 8'(n_out) || ib.out_wr_data != 32'hB000 + 32'(n_out)) e++;
        n_out++;
      end
      if (ib.enable) n_en++;
      ib.outputWrEn = ib.enable && (n_en == 2);
      if (ib.done) begin dc = c; break; end
      tick();
    end
    ib.outputWrEn = 1'b0;
    total++; if (f_in !== 1 || n_in !== 6) begin bad++; $display("FAIL ns_load_in: got first=%0d n=%0d want 1 6", f_in, n_in); end
    total++; if (f_w !== 8 || n_w !== 15) begin bad++; $display("FAIL ns_load_w: got first=%0d n=%0d want 8 15", f_w, n_w); end
    total++; if (f_out !== 26 || n_out !== 10 || e !== 0) begin bad++; $display("FAIL ns_store: got first=%0d n=%0d err=%0d want 26 10 0", f_out, n_out, e); end
    total++; if (dc !== 36) begin bad++; $display("FAIL ns_done: got %0d want 36", dc); end
    for (int k = 0; k < 15; k++) begin
      if (k < 6) begin
        total++; if (ib.input_matrix[k*32 +: 32] !== 32'(k + 1)) begin bad++; $display("FAIL ns_in_slot%0d: got %h want %h", k, ib.input_matrix[k*32 +: 32], 32'(k + 1)); end
      end
      total++; if (ib.weight_matrix[k*32 +: 32] !== 32'h100 + 32'(k)) begin bad++; $display("FAIL ns_w_slot%0d: got %h want %h", k, ib.weight_matrix[k*32 +: 32], 32'h100 + 32'(k)); end
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) begin
      in_mem[k] = 32'(k + 1);
      w_mem[k]  = 32'h100 + 32'(k);
    end
    for (int j = 0; j < 16; j++) begin
      pat_a[j*32 +: 32]  = 32'hA000 + 32'(j);
      garb_a[j*32 +: 32] = 32'hBAD0 + 32'(j);
    end
    for (int j = 0; j < 10; j++) pat_b[j*32 +: 32] = 32'hB000 + 32'(j);
    ia.start = 1'b0; ia.outputWrEn = 1'b0; ia.output_matrix = '0;
    ib.start = 1'b0; ib.outputWrEn = 1'b0; ib.output_matrix = '0;
    test_reset();
    test_full_job();
    test_spurious_handshake();
    test_start_ignored();
    test_reset_mid_job();
    test_back_to_back();
    test_nonsquare();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/sc_mm_sequencer.md
# sc_mm_sequencer

Memory-side sequencer for the stochastic matrix-multiply wrapper. It fetches the input matrix and the weight matrix word-by-word from two read ports and assembles them into the flat buses the wrapper consumes. It then holds `enable` until the wrapper signals a valid result, captures `output_matrix`, and writes it back word-by-word through a write port. It sits between the host/SRAM side and the wrapper and handles the FSM read/write duties for the compute core.

## Interface
- BATCH_SIZE, 4, M rows of input/output matrix
- INPUT_FEATURES, 4, N columns of input, columns of weight
- OUTPUT_FEATURES, 4, O rows of weight, columns of output
- BINARY_PRECISION, 32, P, word width of every element and memory port
- ADDR_WIDTH, 8, memory address width; must be ≥ clog2(max(M*N, O*N, M*O))

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin one job; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job completion
- in_rd_en  out  1  input-memory read strobe
- in_rd_addr  out  ADDR_WIDTH  input-memory element index
- in_rd_data  in  P  data, valid exactly one cycle after in_rd_en
- w_rd_en  out  1  weight-memory read strobe
- w_rd_addr  out  ADDR_WIDTH  weight-memory element index
- w_rd_data  in  P  data, valid one cycle after w_rd_en
- input_matrix  out  P*M*N  element k = m*N+n at bits [k*P +: P]
- weight_matrix  out  P*O*N  element k = o*N+n at bits [k*P +: P]
- enable  out  1  high for the whole COMPUTE state
- output_matrix  in  P*M*O  element j = m*O+o at bits [j*P +: P]
- outputWrEn  in  1  output_matrix valid this cycle
- out_wr_en  out  1  output-memory write strobe
- out_wr_addr  out  ADDR_WIDTH  element index j
- out_wr_data  out  P  element j of the captured result

## Operation
- States: IDLE → LOAD_IN → LOAD_W → COMPUTE → STORE → DONE → IDLE.
- IDLE: all strobes low. `start`=1 → LOAD_IN, element counter ← 0. `start` is ignored in all other states.
- LOAD_IN: in cycles 0..M*N-1, in_rd_en=1 and in_rd_addr=counter (zero-extended). The data returned one cycle later is written to input_matrix slot addr. The state lasts M*N+1 cycles; the final cycle only captures. Then LOAD_W.
- LOAD_W: identical to LOAD_IN over O*N elements using the w_* port, then COMPUTE.
- COMPUTE: enable=1. The first cycle with outputWrEn=1 (including the first COMPUTE cycle) latches output_matrix into an internal result register → STORE. outputWrEn is ignored outside COMPUTE.
- STORE: for j=0..M*O-1, out_wr_en=1, out_wr_addr=j, out_wr_data=result[j*P +: P]; one element per cycle, M*O cycles.
- DONE: done=1 for one cycle → IDLE.
- input_matrix/weight_matrix hold their last loaded values after the job ends until the next load or reset. A partially reloaded matrix exposes mixed old and new elements during LOAD_*.
- Counters are sized to clog2(max count)+1 and never wrap within a state.

## Timing
- Reset (any state, mid-job included): state IDLE; busy, done, enable, all *_en = 0; all addresses, out_wr_data, input_matrix, weight_matrix and result register = 0. A job interrupted by reset is abandoned; no further memory accesses occur.
- All outputs are registered. start is sampled at edge E0; first in_rd_en is high in cycle E0+1.
- Defaults (M=N=O=4): LOAD_IN 17 cycles, LOAD_W 17 cycles. If outputWrEn first arrives in COMPUTE cycle K (K≥1), then enable is high for K cycles, STORE lasts 16 cycles and done fires in cycle 34+K+16+1 after E0.
- enable drops in the cycle after outputWrEn is sampled.
- start held high through DONE launches a new job in the cycle after DONE (back-to-back), with at least one IDLE cycle.

## Test plan
- Reset: hold rst for 3 cycles with random inputs → every output 0, busy=0.
- Full job, defaults: input mem[k]=k+1, weight mem[k]=0x100+k; model returns outputWrEn at COMPUTE cycle 5 with output element j=0xA000+j → input_matrix/weight_matrix slots match; out_wr_* writes addresses 0..15 with data 0xA000..0xA00F in order; done at cycle 56.
- Spurious handshake: outputWrEn=1 during LOAD_W and STORE → ignored; capture occurs only at the COMPUTE pulse.
- start pulsed during LOAD_IN and COMPUTE → no restart; addresses continue monotonically.
- rst asserted at LOAD_W element 2 → next cycle all outputs 0 and IDLE; a fresh start then runs a clean full job.
- Non-square M=2, N=3, O=5: LOAD_IN 7, LOAD_W 16, STORE 10 cycles; slot indexing matches m*N+n, o*N+n and m*O+o.
